aes_matrix_a_sched: RTL
=======================

# aes_matrix_a_sched

Scheduler that drives the pipelined AES-128 core to expand a 128-bit seed into FrodoKEM matrix A. It runs the core's key schedule once per seed, then issues one (row, column) input block per cycle into the core. Ciphertext returns through an internal output FIFO. Issue is credit-limited so the non-stallable core pipeline can never overflow the consumer path.

## Interface
Parameters:
- N_DIM, 640: matrix dimension n; must be a multiple of 8. There are N_DIM/8 blocks per row and N_DIM*N_DIM/8 blocks in total.
- FIFO_DEPTH, 16: output FIFO entries; power of 2, ≥2. Full throughput requires FIFO_DEPTH ≥ core latency + 1, i.e. ≥11.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset, synchronous, active-low.
- i_start  in  1  one-cycle pulse that starts a generation; ignored while o_busy.
- i_seed  in  128  seed; sampled in the cycle i_start is accepted.
- o_busy  out  1  high in KEY, RUN and DRAIN.
- o_done  out  1  one-cycle pulse when the generation completes.
- o_aes_key  out  128  latched seed, to the core key input.
- o_aes_start_key_schedule  out  1  one-cycle pulse to the core key schedule.
- i_aes_done_key_schedule  in  1  core round keys are valid.
- o_aes_data  out  128  core input block.
- o_aes_start  out  1  o_aes_data is valid this cycle (issue).
- i_aes_done  in  1  core result valid this cycle.
- i_aes_data  in  128  core result; valid while i_aes_done is high.
- o_valid  out  1  output FIFO not empty.
- o_data  out  128  FIFO head.
- o_last  out  1  the head is the final block of the matrix.
- i_ready  in  1  consumer accepts; a transfer occurs when o_valid && i_ready.
- o_stall_cnt  out  32  performance counter; see Configuration.

## Operation
- FSM states: IDLE, KEY, RUN, DRAIN.
  - IDLE → KEY on i_start. In the same cycle the block latches i_seed into o_aes_key, clears row/col, and clears the issue and retire counters.
  - On entry to KEY, o_aes_start_key_schedule pulses for exactly one cycle. KEY → RUN when i_aes_done_key_schedule is sampled high, no earlier than the cycle after the pulse.
  - RUN → DRAIN in the cycle the final block is issued.
  - DRAIN → IDLE on the transfer of the final block. o_done pulses in the following cycle.
- Block format:
  - o_aes_data[127:112] = {row[7:0], row[15:8]}
  - o_aes_data[111:96] = {col[7:0], col[15:8]}
  - [95:0] = 0
  - row spans 0..N_DIM-1 and col spans 0, 8, …, N_DIM-8, in row-major order.
  - After each issue, col += 8. When col wraps to 0, row += 1.
- Credit rule: issue happens in RUN only when inflight + fifo_count < FIFO_DEPTH.
  - inflight increments on issue and decrements on i_aes_done; both in the same cycle means no change.
  - The block is latency-agnostic; it relies only on i_aes_done count and order.
- FIFO:
  - Pushes i_aes_data whenever i_aes_done is high.
  - Pops on a transfer; simultaneous push and pop are allowed, including at full.
  - o_last marks the head entry whose retire index equals total-1.
- i_aes_done while inflight == 0 is a protocol error. It is discarded and the counters are not altered.
- Reset, including mid-generation: state goes to IDLE, all counters and FIFO pointers clear, and in-flight core results are ignored until the next i_start.
- Reset values: every output is 0, including o_aes_key and o_stall_cnt.

## Timing
- i_start in cycle 0 → o_busy and o_aes_start_key_schedule high in cycle 1.
- i_aes_done_key_schedule high in cycle k → first o_aes_start in cycle k+1.
- Steady state: one issue per cycle while i_ready is held high and FIFO_DEPTH ≥ core latency + 1.
- A FIFO push in cycle t → o_valid high in cycle t+1 (registered, first-word-fall-through).
- Final transfer in cycle f → o_done high and o_busy low in cycle f+1.
- A new i_start is accepted in cycle f+1 at the earliest.

## Configuration
- AES_SCHED_PERF_EN defined: o_stall_cnt counts RUN cycles in which issue was blocked by credit. It clears on i_start and saturates at 2^32-1.
- AES_SCHED_PERF_EN undefined: o_stall_cnt is tied to 0 and the counter logic is absent.

## Test plan
- Reset: hold i_rst=0 for 3 cycles with i_start=1 → all outputs 0, state IDLE, no key schedule pulse.
- N_DIM=16, i_ready=1, core model with latency 10 and FIFO_DEPTH=16:
  - Exactly 32 issues, one per cycle.
  - Block 0 = 0x0000_0000…, block 1 = 0x0000_0800…, block 2 = 0x0100_0000….
  - 32 transfers in order, o_last on the 32nd only, o_done one cycle after it, stall count 0.
- Backpressure: i_ready=0 from cycle k+1 → exactly FIFO_DEPTH issues then none and the FIFO fills with no loss. Releasing i_ready resumes issue, and all blocks arrive in order. With AES_SCHED_PERF_EN, stall count equals the RUN cycles spent blocked.
- Key schedule wait: i_aes_done_key_schedule delayed 20 cycles → no o_aes_start before cycle k+1.
- Reset mid-RUN after 7 issues → IDLE next cycle and FIFO empty. A new i_start with a different seed regenerates from row 0, col 0 with the new o_aes_key.
- i_start pulsed during RUN → ignored; the sequence and block count are unchanged.

Source files
------------

// File: rtl/aes_matrix_a_sched.sv
// aes_matrix_a_sched: drives a pipelined AES-128 core to expand a seed into FrodoKEM matrix A.
// Latency: first block issued the cycle after key-schedule done; core results reach o_valid one cycle after return.
// Backpressure: issue is credit-limited (inflight + FIFO occupancy < FIFO_DEPTH), so i_ready low never loses data.
// Optional feature: define AES_SCHED_PERF_EN to enable the credit-stall counter on o_stall_cnt.

// Generic synchronous FIFO with registered occupancy and first-word-fall-through read.
// Latency: a push is visible at rdata/count the following cycle.
// Backpressure: push is dropped only when full with no simultaneous pop; pop on empty is ignored.
module aes_sched_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees its slot in the same cycle, so push at full is legal alongside a pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module aes_matrix_a_sched #(
  parameter int N_DIM      = 640,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_seed,
  output logic         o_busy,
  output logic         o_done,
  output logic [127:0] o_aes_key,
  output logic         o_aes_start_key_schedule,
  input  logic         i_aes_done_key_schedule,
  output logic [127:0] o_aes_data,
  output logic         o_aes_start,
  input  logic         i_aes_done,
  input  logic [127:0] i_aes_data,
  output logic         o_valid,
  output logic [127:0] o_data,
  output logic         o_last,
  input  logic         i_ready,
  output logic [31:0]  o_stall_cnt
);

  localparam int TOTAL = N_DIM * N_DIM / 8;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0]   LAST_IDX = 32'(TOTAL - 1);
  localparam logic [15:0]   COL_LAST = 16'(N_DIM - 8);
  localparam logic [CW:0]   CREDITS  = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state;
  logic [127:0]  key_r;
  logic          ks_pulse;
  logic          busy_r;
  logic          done_r;
  logic [15:0]   row;
  logic [15:0]   col;
  logic [31:0]   issue_cnt;
  logic [31:0]   retire_cnt;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic [128:0]  fifo_head;

  logic start_acc;
  logic credit_ok;
  logic issue;
  logic push;
  logic xfer;

  assign start_acc = i_start && (state == IDLE);

  // Every issued block must have a guaranteed FIFO slot when it comes back,
  // because the core pipeline cannot be stalled.
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_cnt}) < CREDITS;

  // Issue is decoded from registered state so the credit check and the
  // issue happen in the same cycle without a one-cycle bubble.
  assign issue = (state == RUN) && credit_ok;

  // A result with nothing outstanding is a stray (e.g. from before a reset) and is dropped.
  assign push = i_aes_done && (inflight != '0);

  assign xfer = o_valid && i_ready;

  // Main FSM: seed latch, key-schedule handshake, row-major block walk, drain.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= IDLE;
      key_r     <= '0;
      ks_pulse  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      row       <= '0;
      col       <= '0;
      issue_cnt <= '0;
    end else begin
      ks_pulse <= 1'b0;
      done_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_acc) begin
            state     <= KEY;
            key_r     <= i_seed;
            ks_pulse  <= 1'b1;
            busy_r    <= 1'b1;
            row       <= '0;
            col       <= '0;
            issue_cnt <= '0;
          end
        end
        KEY: begin
          // Ignore done during the pulse cycle: it may still reflect the previous key.
          if (i_aes_done_key_schedule && !ks_pulse) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 16'd8;
            end
            if (issue_cnt == LAST_IDX) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (xfer && o_last) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outstanding-block and retire-index tracking, cleared at each generation start.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      inflight   <= '0;
      retire_cnt <= '0;
    end else if (start_acc) begin
      inflight   <= '0;
      retire_cnt <= '0;
    end else begin
      case ({issue, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (push) begin
        retire_cnt <= retire_cnt + 1'b1;
      end
    end
  end

  // Results are tagged with a last flag on entry so the head can report it directly.
  aes_sched_fifo #(
    .WIDTH (129),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (i_clk),
    .rst_n (i_rst),
    .push  (push),
    .wdata ({(retire_cnt == LAST_IDX), i_aes_data}),
    .pop   (xfer),
    .rdata (fifo_head),
    .count (fifo_cnt)
  );

  assign o_busy                   = busy_r;
  assign o_done                   = done_r;
  assign o_aes_key                = key_r;
  assign o_aes_start_key_schedule = ks_pulse;
  assign o_aes_start              = issue;
  // Row and column are encoded as little-endian 16-bit fields.
  assign o_aes_data               = {row[7:0], row[15:8], col[7:0], col[15:8], 96'h0};
  assign o_valid                  = (fifo_cnt != '0);
  // Gate the uninitialised storage so outputs read zero while empty.
  assign o_data                   = o_valid ? fifo_head[127:0] : 128'h0;
  assign o_last                   = o_valid && fifo_head[128];

`ifdef AES_SCHED_PERF_EN
  logic [31:0] stall_cnt;

  // Count RUN cycles where credit blocked issue; saturates rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && !credit_ok && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt;
`else
  assign o_stall_cnt = 32'h0;
`endif

endmodule
